// File: rtl/ppu_video_pkg.sv
// Shared PPU video timing constants, pattern encoding and bar colour table.
// Imported by the test-pattern generator and the VGA scan converter.
package ppu_video_pkg;

  localparam int unsigned PPU_HPERIOD = 341;
  localparam int unsigned PPU_VPERIOD = 262;
  localparam int unsigned PPU_HDISP   = 256;
  localparam int unsigned PPU_VDISP   = 240;
  localparam int unsigned PPU_DELAY   = 3;

  localparam int unsigned PPU_VBLANK_SET_LINE = 241;
  localparam int unsigned PPU_VBLANK_CLR_LINE = 261;

  localparam logic [5:0] PPU_BLACK = 6'h0F;
  localparam logic [5:0] PPU_WHITE = 6'h30;

  typedef enum logic [1:0] {
    PatSolid    = 2'd0,
    PatBars     = 2'd1,
    PatChecker  = 2'd2,
    PatGradient = 2'd3
  } ppu_pattern_e;

  // Entry [0] is the leftmost bar.
  localparam logic [7:0][5:0] PPU_BAR_LUT = {
    6'h0F, 6'h12, 6'h16, 6'h24, 6'h2A, 6'h2C, 6'h28, 6'h30
  };

endpackage

// File: rtl/ppu_pattern_lut.sv
// Combinational pattern generator: mode, pixel coordinates and frame count
// to a 6-bit palette index. Only the coordinate bits a pattern can use are
// passed in.
module ppu_pattern_lut
  import ppu_video_pkg::*;
(
  input  ppu_pattern_e i_mode,
  input  logic [7:0]   i_x,
  input  logic [1:0]   i_y_hi,      // y[7:6]
  input  logic         i_y_b3,      // y[3]
  input  logic [3:0]   i_frame_lsb, // frame_cnt[3:0]
  input  logic [5:0]   i_solid,
  output logic [5:0]   o_index
);

  // The low nibble of the mod-256 scroll sum depends only on the low nibbles.
  logic [3:0] w_xs;
  assign w_xs = i_x[3:0] + i_frame_lsb;

  // Select the palette index for the latched pattern
  always_comb begin
    o_index = PPU_BLACK;
    unique case (i_mode)
      PatSolid:    o_index = i_solid;
      PatBars:     o_index = PPU_BAR_LUT[i_x[7:5]];
      PatChecker:  o_index = (w_xs[3] ^ i_y_b3) ? PPU_WHITE : PPU_BLACK;
      PatGradient: o_index = {i_y_hi, i_x[7:4]};
    endcase
  end

endmodule

// File: rtl/ppu_test_pattern.sv
// Stand-alone replacement for the PPU pixel interface: NES dot/line counters
// plus a 3-stage test-pattern pipeline aligned so column x appears at hcnt x+3.
// Optional build macro PPU_ODD_FRAME_SKIP_EN: skip dot 340 of the pre-render
// line on odd frames.
module ppu_test_pattern
  import ppu_video_pkg::*;
#(
  parameter logic [5:0] SOLID_DEFAULT = 6'h21
) (
  input  logic       clk_ppu,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [5:0] solid_color,
  output logic [7:0] ppu_pixel,
  output logic [8:0] ppu_hcnt,
  output logic [8:0] ppu_vcnt,
  output logic       ppu_vblank,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  logic [8:0]   r_hcnt;
  logic [8:0]   r_vcnt;
  logic [7:0]   r_frame_cnt;
  logic         r_vblank;
  ppu_pattern_e r_mode_q;
  logic [5:0]   r_solid_q;

  logic         r_s1_active;
  logic [7:0]   r_s1_x;
  logic [1:0]   r_s1_y_hi;
  logic         r_s1_y_b3;
  logic [7:0]   r_s2_pixel;
  logic [7:0]   r_s3_pixel;

  logic         w_h_last;
  logic         w_v_last;
  logic         w_active;
  logic [5:0]   w_index;

  assign w_v_last = (r_vcnt == 9'(PPU_VPERIOD - 1));

`ifdef PPU_ODD_FRAME_SKIP_EN
  assign w_h_last = (r_hcnt == 9'(PPU_HPERIOD - 1)) ||
                    (r_frame_cnt[0] && w_v_last && (r_hcnt == 9'(PPU_HPERIOD - 2)));
`else
  assign w_h_last = (r_hcnt == 9'(PPU_HPERIOD - 1));
`endif

  // Dot/line counters; pattern inputs are only sampled at the frame wrap
  always_ff @(posedge clk_ppu) begin
    if (reset) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_frame_cnt <= '0;
      r_mode_q    <= PatSolid;
      r_solid_q   <= SOLID_DEFAULT;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      if (w_v_last) begin
        r_vcnt      <= '0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_mode_q    <= ppu_pattern_e'(mode);
        r_solid_q   <= solid_color;
      end else begin
        r_vcnt <= r_vcnt + 9'd1;
      end
    end else begin
      r_hcnt <= r_hcnt + 9'd1;
    end
  end

  // Vblank flag: changes on the edge leaving dot 0 of the set/clear lines
  always_ff @(posedge clk_ppu) begin
    if (reset) begin
      r_vblank <= 1'b0;
    end else if (r_hcnt == 9'd0 && r_vcnt == 9'(PPU_VBLANK_SET_LINE)) begin
      r_vblank <= 1'b1;
    end else if (r_hcnt == 9'd0 && r_vcnt == 9'(PPU_VBLANK_CLR_LINE)) begin
      r_vblank <= 1'b0;
    end
  end

  // Decoding PPU_DELAY dots early means x = hcnt - 3 at the output; the
  // underflowed dots 0..2 map to hcnt 338..340 of the previous line, which
  // are outside the active width.
  assign w_active = (r_hcnt < 9'(PPU_HDISP)) && (r_vcnt < 9'(PPU_VDISP));

  // Stage 1: coordinate and active decode
  always_ff @(posedge clk_ppu) begin
    if (reset) begin
      r_s1_active <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y_hi   <= '0;
      r_s1_y_b3   <= 1'b0;
    end else begin
      r_s1_active <= w_active;
      r_s1_x      <= r_hcnt[7:0];
      r_s1_y_hi   <= r_vcnt[7:6];
      r_s1_y_b3   <= r_vcnt[3];
    end
  end

  ppu_pattern_lut u_lut (
    .i_mode      (r_mode_q),
    .i_x         (r_s1_x),
    .i_y_hi      (r_s1_y_hi),
    .i_y_b3      (r_s1_y_b3),
    .i_frame_lsb (r_frame_cnt[3:0]),
    .i_solid     (r_solid_q),
    .o_index     (w_index)
  );

  // Stages 2 and 3: pattern lookup then output register
  always_ff @(posedge clk_ppu) begin
    if (reset) begin
      r_s2_pixel <= {2'b00, PPU_BLACK};
      r_s3_pixel <= {2'b00, PPU_BLACK};
    end else begin
      r_s2_pixel <= r_s1_active ? {2'b00, w_index} : {2'b00, PPU_BLACK};
      r_s3_pixel <= r_s2_pixel;
    end
  end

  assign ppu_pixel   = r_s3_pixel;
  assign ppu_hcnt    = r_hcnt;
  assign ppu_vcnt    = r_vcnt;
  assign ppu_vblank  = r_vblank;
  assign frame_start = (r_hcnt == 9'd0) && (r_vcnt == 9'd0);
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_ppu_test_pattern.sv
// Bench for ppu_test_pattern: four instances, one per pattern in frame 1,
// compared every cycle against a frame-position model (cycle-in-frame index
// split into dot and line with division).
module tb_ppu_test_pattern;

  localparam int NI = 4;
  localparam int HP = 341;
  localparam int VP = 262;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode_in  [NI];
  logic [5:0] solid_in [NI];
  logic [7:0] pix      [NI];
  logic [8:0] hc       [NI];
  logic [8:0] vc       [NI];
  logic       vb       [NI];
  logic       fs       [NI];
  logic [7:0] fcnt     [NI];

  int    bar_lut [8]  = '{'h30, 'h28, 'h2C, 'h2A, 'h24, 'h16, 'h12, 'h0F};
  string pix_tag [NI] = '{"pix0", "pix1", "pix2", "pix3"};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int mt;          // cycle index within the current frame
  int mfc;         // frame count
  int mq  [NI];    // latched pattern per instance
  int msq [NI];    // latched solid colour per instance

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    ppu_test_pattern #(
      .SOLID_DEFAULT (6'(8'h21 + 3 * gi))
    ) u_dut (
      .clk_ppu     (clk),
      .reset       (reset),
      .mode        (mode_in[gi]),
      .solid_color (solid_in[gi]),
      .ppu_pixel   (pix[gi]),
      .ppu_hcnt    (hc[gi]),
      .ppu_vcnt    (vc[gi]),
      .ppu_vblank  (vb[gi]),
      .frame_start (fs[gi]),
      .frame_cnt   (fcnt[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int solid_default(int k);
    return 'h21 + 3 * k;
  endfunction

  function automatic int frame_len(int fc);
    int skip;
`ifdef PPU_ODD_FRAME_SKIP_EN
    skip = fc % 2;
`else
    skip = fc * 0;
`endif
    return HP * VP - skip;
  endfunction

  // Expected palette index for the dot currently shown at (h, v).
  function automatic int exp_pixel(int h, int v, int fc, int md, int sc);
    int x, y, xs;
    if (h < 3 || h > 258 || v > 239) return 'h0F;
    x = h - 3;
    y = v;
    case (md)
      0: return sc;
      1: return bar_lut[x / 32];
      2: begin
        xs = (x + fc) % 256;
        return (((xs / 8) % 2) != ((y / 8) % 2)) ? 'h30 : 'h0F;
      end
      default: return (y / 64) * 16 + x / 16;
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      mt  = 0;
      mfc = 0;
      for (int k = 0; k < NI; k++) begin
        mq[k]  = 0;
        msq[k] = solid_default(k);
      end
    end else begin
      mt++;
      if (mt == frame_len(mfc)) begin
        mt  = 0;
        mfc = (mfc + 1) % 256;
        for (int k = 0; k < NI; k++) begin
          mq[k]  = int'(mode_in[k]);
          msq[k] = int'(solid_in[k]);
        end
      end
    end
  endtask

  task automatic compare_all();
    int h, v, ev_vb;
    h = mt % HP;
    v = mt / HP;
    ev_vb = ((v > 241 && v < 261) || (v == 241 && h >= 1) || (v == 261 && h == 0)) ? 1 : 0;
    check("counters", {hc[0], vc[0], vb[0], fs[0], fcnt[0]},
          {9'(h), 9'(v), 1'(ev_vb), (mt == 0), 8'(mfc)});
    for (int k = 0; k < NI; k++) begin
      check(pix_tag[k], pix[k], 8'(exp_pixel(h, v, mfc, mq[k], msq[k])));
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare_all();
  endtask

  initial begin
    int fs_seen = 0;
    int fs_cyc  = 0;
    int vb_cnt  = 0;
    int h, v;
    bit reached = 1'b0;

    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      mode_in[k]  = 2'($urandom_range(0, 3));
      solid_in[k] = 6'($urandom_range(0, 63));
    end
    repeat (5) run_cycle();
    // First cycle of frame 0 as reset is released.
    check("rel_state", {hc[0], vc[0], fs[0], vb[0], pix[0]},
          {9'd0, 9'd0, 1'b1, 1'b0, 8'h0F});
    reset   = 1'b0;
    fs_seen = 1;
    fs_cyc  = cyc;

    while (!reached && cyc < 95000) begin
      run_cycle();
      h = mt % HP;
      v = mt / HP;
      if (fs_seen == 1 && fs[0] === 1'b1) begin
        check("frame_len", cyc - fs_cyc, HP * VP);
        check("frame_cnt1", fcnt[0], 8'd1);
        check("vblank_len", vb_cnt, 20 * HP);
        fs_seen = 2;
      end
      if (fs_seen == 1 && vb[0] === 1'b1) vb_cnt++;
      if (mfc == 1) begin
        if (v == 0  && h == 10)  check("chk_f1_l0",  pix[2], 8'h30);
        if (v == 8  && h == 10)  check("chk_f1_l8",  pix[2], 8'h0F);
        if (v == 10 && h == 3)   check("bars_h3",    pix[1], 8'h30);
        if (v == 10 && h == 35)  check("bars_h35",   pix[1], 8'h28);
        if (v == 10 && h == 258) check("bars_h258",  pix[1], 8'h0F);
        if (v == 10 && h == 2)   check("bars_h2",    pix[1], 8'h0F);
        if (v == 5  && h == 67)  check("grad_x40",   pix[3], 8'h04);
      end
      // Random input churn; in the last 100 cycles of frame 0 park instance k on mode k.
      for (int k = 0; k < NI; k++) begin
        if (mfc == 0 && mt >= HP * VP - 100) begin
          mode_in[k] = 2'(k);
          if (mt == HP * VP - 100) solid_in[k] = 6'($urandom_range(0, 63));
        end else if ($urandom_range(0, 499) == 0) begin
          mode_in[k]  = 2'($urandom_range(0, 3));
          solid_in[k] = 6'($urandom_range(0, 63));
        end
      end
      reached = (mfc == 1 && mt == 11 * HP);
    end
    if (!reached) check("reach_f1_l11", 0, 1);
    if (fs_seen != 2) check("second_frame_start", fs_seen, 2);

    // Mid-frame reset restores frame 0, dot 0 and the default solid colour.
    reset = 1'b1;
    run_cycle();
    run_cycle();
    check("mid_rst", {hc[0], vc[0], fcnt[0], fs[0], vb[0], pix[0]},
          {9'd0, 9'd0, 8'd0, 1'b1, 1'b0, 8'h0F});
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      run_cycle();
      if (mt == 50) check("solid_dflt", pix[3], 8'h2A);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
